// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle with c_LANES parallel lanes sharing one tdata vector.
// Lane i occupies tdata[i*c_WIDTH +: c_WIDTH].
interface axis_rr_arbiter_if #(
  parameter int c_WIDTH = 8,
  parameter int c_LANES = 1
);
  logic [c_LANES*c_WIDTH-1:0] tdata;
  logic [c_LANES-1:0]         tvalid;
  logic [c_LANES-1:0]         tready;
  logic [c_LANES-1:0]         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter: c_PORTS AXI-Stream slaves share one master port.
// The grant is held from the first beat through the tlast beat; data path is combinational.
module axis_rr_arbiter #(
  parameter int c_WIDTH = 8,
  parameter int c_PORTS = 4,
  parameter int c_IDX_W = 2,
  parameter int c_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  axis_rr_arbiter_if.slave   s_axis,
  axis_rr_arbiter_if.master  m_axis,
  output logic [c_IDX_W-1:0] grant_id,
  output logic               busy,
  output logic [c_CNT_W-1:0] pkt_count
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_IDX_W-1:0]   r_rr_ptr;
  logic [c_IDX_W-1:0]   w_rr_ptr_next;
  logic [c_IDX_W-1:0]   r_grant;
  logic [c_IDX_W-1:0]   w_grant_next;
  logic [c_CNT_W-1:0]   r_pkt_count;
  logic [c_CNT_W-1:0]   w_pkt_count_next;

  logic                 w_busy;
  logic                 w_found;
  logic [c_IDX_W-1:0]   w_winner;
  logic [c_IDX_W:0]     w_cand;
  logic                 w_last_xfer;
  logic [c_WIDTH-1:0]   w_sel_data;

  assign w_busy      = (r_state == BUSY);
  assign w_last_xfer = w_busy && s_axis.tvalid[r_grant] && m_axis.tready[0]
                       && s_axis.tlast[r_grant];

  // Search starts at the round-robin pointer and wraps; one spare bit keeps
  // the sum from overflowing before the modulo correction.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 0; k < c_PORTS; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
      if (w_cand >= (c_IDX_W+1)'(c_PORTS)) begin
        w_cand = w_cand - (c_IDX_W+1)'(c_PORTS);
      end
      if (!w_found && s_axis.tvalid[w_cand[c_IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[c_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_rr_ptr_next    = r_rr_ptr;
    w_grant_next     = r_grant;
    w_pkt_count_next = r_pkt_count;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_next = BUSY;
          w_grant_next = w_winner;
        end
      end
      BUSY: begin
        if (w_last_xfer) begin
          w_state_next     = IDLE;
          w_rr_ptr_next    = (r_grant == c_IDX_W'(c_PORTS-1)) ? '0
                                                              : r_grant + c_IDX_W'(1);
          w_pkt_count_next = r_pkt_count + c_CNT_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_pkt_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_grant     <= w_grant_next;
      r_pkt_count <= w_pkt_count_next;
    end
  end

  always_comb begin
    w_sel_data = '0;
    if (w_busy) begin
      w_sel_data = s_axis.tdata[r_grant*c_WIDTH +: c_WIDTH];
    end
  end

  assign m_axis.tdata  = w_sel_data;
  assign m_axis.tvalid = {w_busy && s_axis.tvalid[r_grant]};
  assign m_axis.tlast  = {w_busy && s_axis.tlast[r_grant]};

  for (genvar gi = 0; gi < c_PORTS; gi++) begin : g_tready
    assign s_axis.tready[gi] = w_busy && (r_grant == c_IDX_W'(gi)) && m_axis.tready[0];
  end

  assign grant_id  = r_grant;
  assign busy      = w_busy;
  assign pkt_count = r_pkt_count;

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one AXI-Stream master port between c_PORTS slave streams.
- A grant is held for a whole packet, from first beat to the tlast beat, so packets never interleave.
- Sits in front of single-stream consumers such as axis_loopback or a DMA/output channel. Data path is zero-latency pass-through; only the grant decision is registered.

Parameters:
- c_WIDTH, 8, tdata width in bits.
- c_PORTS, 4, number of slave streams (2..16).
- c_IDX_W, 2, width of grant index; must equal clog2(c_PORTS), minimum 1.
- c_CNT_W, 16, width of the completed-packet counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  c_PORTS*c_WIDTH  packed slave data; port i uses bits [i*c_WIDTH +: c_WIDTH].
- s_axis_tvalid  in  c_PORTS  per-port valid.
- s_axis_tready  out  c_PORTS  per-port ready.
- s_axis_tlast  in  c_PORTS  per-port end of packet.
- m_axis_tdata  out  c_WIDTH  granted port's data.
- m_axis_tvalid  out  1  granted port's valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  granted port's tlast.
- grant_id  out  c_IDX_W  index of the current or last granted port.
- busy  out  1  high while a packet grant is held.
- pkt_count  out  c_CNT_W  number of completed packets; wraps modulo 2^c_CNT_W.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0, pkt_count=0.
  - Reset overrides everything, including an in-flight packet; that packet is abandoned with no flush.
- Combinational outputs in IDLE:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - s_axis_tready all 0.
- Combinational outputs in BUSY, with g=grant_id:
  - m_axis_tdata = slave data of port g.
  - m_axis_tvalid = s_axis_tvalid[g].
  - m_axis_tlast = s_axis_tlast[g].
  - s_axis_tready[g] = m_axis_tready; all other tready bits = 0.
- IDLE -> BUSY:
  - Triggered when any s_axis_tvalid is set.
  - Winner = first port with tvalid=1, searching rr_ptr, rr_ptr+1, ... modulo c_PORTS.
  - grant_id <= winner; busy <= 1.
  - One-cycle arbitration bubble: the first beat can transfer at the earliest in the cycle after valid is seen.
- BUSY, no tlast transfer: stay in BUSY.
  - The grant holds through any number of beats, tvalid gaps and downstream stalls.
  - Other ports' tvalid is ignored.
- BUSY -> IDLE: on a transfer (m_axis_tvalid & m_axis_tready) with m_axis_tlast=1.
  - rr_ptr <= (grant_id+1) mod c_PORTS.
  - busy <= 0.
  - pkt_count <= pkt_count+1.
  - grant_id keeps its value.
- Back-to-back packets: IDLE lasts exactly one cycle between packets. Max throughput is N beats per N+1 cycles per packet.
- Single-beat packet (tlast on first beat): granted, transfers, returns to IDLE; counts as one packet.
- Wrap-around:
  - rr_ptr wraps from c_PORTS-1 to 0.
  - pkt_count wraps from all-ones to 0 with no flag.
- Fairness: with all ports continuously valid, grants rotate 0,1,2,...,c_PORTS-1,0. No port waits more than c_PORTS-1 packets.
- tvalid deasserted by the requester after the grant (protocol violation upstream): the arbiter keeps the grant until that port's tlast transfers. No timeout.
- AXI-Stream rules hold on the m side: when m_axis_tvalid=1 and m_axis_tready=0, tdata and tlast stay stable, provided the upstream port obeys AXI.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no valid -> m_axis_tvalid=0, s_axis_tready=4'b0000, busy=0, pkt_count=0.
- Single port, 3-beat packet: port 2 sends 0x11, 0x22, 0x33(tlast), m_axis_tready=1 -> grant_id=2 one cycle after valid; m side carries 0x11, 0x22, 0x33 on consecutive cycles; pkt_count=1; busy=0 afterwards.
- Round-robin: all 4 ports hold 2-beat packets continuously -> grant order 0,1,2,3,0; each gap between packets is exactly 1 cycle; no interleaved beats.
- Backpressure: m_axis_tready toggles 1,0,0,1 mid-packet on port 1 -> beats held stable while stalled; s_axis_tready[1] mirrors m_axis_tready; other ready bits stay 0; no beat lost or duplicated.
- Pointer skip: rr_ptr=1 after port 0's packet, only port 3 valid -> grant_id=3; next rr_ptr=0.
- Reset mid-packet and counter wrap:
  - rst asserted during beat 2 of a 4-beat packet -> next cycle state=IDLE, tready=0, pkt_count=0.
  - Separate run with c_CNT_W=2 and 5 packets -> pkt_count reads 1.
